// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types for the configurable SPI master:
//   spi_state_e : transfer FSM states (idle, lead-in, bit transfer, trail-out)
//   spi_mode_t  : per-transfer mode captured when a request is accepted
// No ports; imported by spi_master_cfg.
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_XFER  = 2'd2,
    S_TRAIL = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/spi_tick_div.sv
// ---------------------------------------------------------------------------
// spi_tick_div
// Half-period tick generator: tick is high on every DIV-th cycle counted from
// the last clear, then the count wraps.
// Ports:
//   clk  : clock (rising edge)
//   rst  : synchronous active-high reset
//   clr  : synchronous clear, holds the count at zero while high
//   tick : high in the last cycle of each DIV-cycle half-period
// ---------------------------------------------------------------------------
module spi_tick_div #(
  parameter int DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_cfg.sv
// ---------------------------------------------------------------------------
// spi_master_cfg
// Single-word SPI master with per-transfer mode (cpol/cpha/bit order) and
// slave select. A transfer is a lead-in half-period, 2N SCLK edges and a
// trail-out half-period; the received word is presented with a one-cycle
// arrived pulse when the block returns to idle.
//
// Optional feature: define SPI_LOOPBACK_EN to add a 'loopback' input; when it
// is 1 at accept, the master samples its own MOSI and keeps all CS_n high.
//
// Ports:
//   Clock, Reset        : clock and synchronous active-high reset
//   send / ready        : start request / idle indication
//   data, cs_sel        : transmit word and slave index, captured on accept
//   cpol, cpha,
//   lsb_first           : transfer mode, captured on accept
//   loopback            : (SPI_LOOPBACK_EN only) internal MOSI->MISO path
//   arrived, dataO      : completion pulse and received word
//   SCLK, MOSI, MISO    : serial interface
//   CS_n                : active-low chip selects
// ---------------------------------------------------------------------------
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 5,
  parameter int NCS = 1
) (
  input  logic                                   Clock,
  input  logic                                   Reset,
  input  logic                                   send,
  output logic                                   ready,
  input  logic [N-1:0]                           data,
  input  logic [((NCS > 1) ? $clog2(NCS) : 1)-1:0] cs_sel,
  input  logic                                   cpol,
  input  logic                                   cpha,
  input  logic                                   lsb_first,
`ifdef SPI_LOOPBACK_EN
  input  logic                                   loopback,
`endif
  output logic                                   arrived,
  output logic [N-1:0]                           dataO,
  output logic                                   SCLK,
  output logic                                   MOSI,
  input  logic                                   MISO,
  output logic [NCS-1:0]                         CS_n
);

  generate
    if (N < 2) begin : g_bad_n
      $error("spi_master_cfg: N must be >= 2");
    end
    if (DIV < 1) begin : g_bad_div
      $error("spi_master_cfg: DIV must be >= 1");
    end
    if (NCS < 1) begin : g_bad_ncs
      $error("spi_master_cfg: NCS must be >= 1");
    end
  endgenerate

  localparam int EW = $clog2(2 * N + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * N - 1);

  // Current output bit of a word in the selected order.
  function automatic logic head_bit(input logic [N-1:0] v, input logic lsb);
    return lsb ? v[0] : v[N-1];
  endfunction

  // Drop the current output bit, filling with zero.
  function automatic logic [N-1:0] shift_out(input logic [N-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[N-1:1]} : {v[N-2:0], 1'b0};
  endfunction

  // Insert a received bit so the first one ends at the first-transmitted end.
  function automatic logic [N-1:0] shift_in(input logic [N-1:0] v, input logic b,
                                             input logic lsb);
    return lsb ? {b, v[N-1:1]} : {v[N-2:0], b};
  endfunction

  spi_state_e      state_q, state_d;
  spi_mode_t       mode_q, mode_d;
  logic            lb_q, lb_d;
  logic [NCS-1:0]  cs_q, cs_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic [EW-1:0]   edge_cnt_q, edge_cnt_d;
  logic [N-1:0]    tx_q, tx_d;
  logic [N-1:0]    rx_q, rx_d;
  logic [N-1:0]    dout_q, dout_d;
  logic            arrived_q, arrived_d;

  logic            lb_in;
  logic            tick;
  logic            miso_eff;
  logic            leading;
  logic            sample_now;

`ifdef SPI_LOOPBACK_EN
  assign lb_in = loopback;
`else
  assign lb_in = 1'b0;
`endif

  // The divider free-runs during a transfer; it is held clear in idle so the
  // first tick lands exactly DIV cycles after lead-in entry, and each state
  // change coincides with a wrap, so later states also start at zero.
  spi_tick_div #(.DIV(DIV)) u_tick_div (
    .clk  (Clock),
    .rst  (Reset),
    .clr  (state_q == S_IDLE),
    .tick (tick)
  );

  assign miso_eff   = lb_q ? mosi_q : MISO;
  // Edges are numbered from 1; odd (leading) edges have an even count so far.
  assign leading    = ~edge_cnt_q[0];
  // cpha=0 samples on leading edges, cpha=1 on trailing edges.
  assign sample_now = leading ^ mode_q.cpha;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lb_d       = lb_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    edge_cnt_d = edge_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    dout_d     = dout_q;
    arrived_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (send) begin
          mode_d.cpol      = cpol;
          mode_d.cpha      = cpha;
          mode_d.lsb_first = lsb_first;
          lb_d             = lb_in;
          // Out-of-range selects leave every line high (dummy transfer).
          cs_d = '1;
          for (int i = 0; i < NCS; i++) begin
            if (!lb_in && (int'(cs_sel) == i)) cs_d[i] = 1'b0;
          end
          sclk_d     = cpol;
          edge_cnt_d = '0;
          rx_d       = '0;
          // cpha=0 presents the first bit immediately; cpha=1 waits for the
          // first leading edge to shift it out.
          if (cpha) begin
            mosi_d = 1'b0;
            tx_d   = data;
          end else begin
            mosi_d = head_bit(data, lsb_first);
            tx_d   = shift_out(data, lsb_first);
          end
          state_d = S_LEAD;
        end
      end

      S_LEAD, S_XFER: begin
        if (tick) begin
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + 1'b1;
          if (sample_now) begin
            rx_d = shift_in(rx_q, miso_eff, mode_q.lsb_first);
          end else begin
            mosi_d = head_bit(tx_q, mode_q.lsb_first);
            tx_d   = shift_out(tx_q, mode_q.lsb_first);
          end
          if (state_q == S_LEAD)             state_d = S_XFER;
          else if (edge_cnt_q == LAST_EDGE)  state_d = S_TRAIL;
        end
      end

      S_TRAIL: begin
        if (tick) begin
          state_d   = S_IDLE;
          cs_d      = '1;
          mosi_d    = 1'b0;
          dout_d    = rx_q;
          arrived_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      lb_q       <= 1'b0;
      cs_q       <= '1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      edge_cnt_q <= '0;
      dout_q     <= '0;
      arrived_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lb_q       <= lb_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      edge_cnt_q <= edge_cnt_d;
      dout_q     <= dout_d;
      arrived_q  <= arrived_d;
    end
  end

  // Shift registers: reloaded on every accept, no reset needed
  always_ff @(posedge Clock) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign ready   = (state_q == S_IDLE) && !Reset;
  assign arrived = arrived_q;
  assign dataO   = dout_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign CS_n    = cs_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// ---------------------------------------------------------------------------
// tb_spi_master_cfg
// Directed bench for spi_master_cfg (N=8, DIV=2, NCS=4) with a behavioural
// SPI slave. A second instance with NCS=3 covers the out-of-range select,
// since a 2-bit cs_sel cannot encode values above 3.
// ---------------------------------------------------------------------------
module tb_spi_master_cfg;

  localparam int N   = 8;
  localparam int DIV = 2;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] cs_sel = 2'd0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
`ifdef SPI_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif
  logic       ready, arrived, SCLK, MOSI;
  logic       MISO = 1'b0;
  logic [7:0] dataO;
  logic [3:0] CS_n;

  logic       ready3, arrived3, sclk3, mosi3;
  logic [7:0] dataO3;
  logic [2:0] cs_n3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  spi_master_cfg #(.N(N), .DIV(DIV), .NCS(4)) dut (
    .Clock(Clock), .Reset(Reset), .send(send), .ready(ready), .data(data),
    .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .arrived(arrived), .dataO(dataO), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .CS_n(CS_n)
  );

  spi_master_cfg #(.N(N), .DIV(DIV), .NCS(3)) dut_n3 (
    .Clock(Clock), .Reset(Reset), .send(send), .ready(ready3), .data(data),
    .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .arrived(arrived3), .dataO(dataO3), .SCLK(sclk3), .MOSI(mosi3), .MISO(MISO),
    .CS_n(cs_n3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model: shifts s_seq out (first bit = s_seq[7]) and records MOSI in
  // transmission order (first bit ends in mosi_seq[7]).
  logic [7:0] s_seq = 8'h00;
  logic       s_cpha = 1'b0;
  logic [7:0] mosi_seq = 8'h00;
  int         edge_no = 0;
  int         s_idx = 0;
  logic       sclk_prev = 1'b0;
  logic       cs_act_prev = 1'b0;

  always @(negedge Clock) begin
    logic cs_act;
    logic lead;
    cs_act = (CS_n != 4'hF);
    if (cs_act && !cs_act_prev) begin
      edge_no  = 0;
      s_idx    = 0;
      mosi_seq = 8'h00;
      MISO     = s_cpha ? 1'b0 : s_seq[7];
    end else if (cs_act && (SCLK != sclk_prev)) begin
      edge_no++;
      lead = (edge_no % 2) == 1;
      if (lead ^ s_cpha) begin
        mosi_seq = {mosi_seq[6:0], MOSI};
      end else if (s_cpha) begin
        MISO = (s_idx < 8) ? s_seq[7 - s_idx] : 1'b0;
        s_idx++;
      end else begin
        s_idx++;
        MISO = (s_idx < 8) ? s_seq[7 - s_idx] : 1'b0;
      end
    end else if (!cs_act) begin
      MISO = 1'b0;
    end
    sclk_prev   = SCLK;
    cs_act_prev = cs_act;
  end

  logic [2:0] cs3_acc;
  logic       arr3_end;

  task automatic xfer(input logic [7:0] d, input logic [1:0] sel, input logic cp,
                      input logic ch, input logic lsb, input logic [7:0] sseq,
                      input logic [7:0] exp_mosi, input logic [7:0] exp_dout,
                      input logic [3:0] exp_cs, input logic disturb);
    int  cnt;
    bit  got;
    @(negedge Clock);
    data = d; cs_sel = sel; cpol = cp; cpha = ch; lsb_first = lsb;
    s_seq = sseq; s_cpha = ch; send = 1'b1;
    @(posedge Clock); #1;
    send = 1'b0;
    cs3_acc = cs_n3;
    check("cs_sel", 32'(CS_n), 32'(exp_cs));
    check("sclk_lead", 32'(SCLK), 32'(cp));
    check("mosi_lead", 32'(MOSI), ch ? 32'd0 : (lsb ? 32'(d[0]) : 32'(d[7])));
    check("ready_busy", 32'(ready), 32'd0);
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 100) begin
      @(posedge Clock); #1;
      cnt++;
      if (arrived) begin
        got = 1'b1;
        arr3_end = arrived3;
      end else if (disturb) begin
        if (cnt == 5) begin
          data = ~data; cpol = ~cpol; cpha = ~cpha; lsb_first = ~lsb_first;
          cs_sel = cs_sel + 2'd1;
        end
        if (cnt == 7) send = 1'b1;
        if (cnt == 8) send = 1'b0;
      end
    end
    check("arrive_latency", 32'(cnt), 32'd34);
    check("dataO", 32'(dataO), 32'(exp_dout));
    check("cs_idle", 32'(CS_n), 32'hF);
    check("sclk_idle", 32'(SCLK), 32'(cp));
    check("mosi_idle", 32'(MOSI), 32'd0);
    if (exp_cs != 4'hF) begin
      check("mosi_seq", 32'(mosi_seq), 32'(exp_mosi));
      check("edge_count", 32'(edge_no), 32'd16);
    end
    @(posedge Clock); #1;
    check("arrived_pulse", 32'(arrived), 32'd0);
    check("no_queue", 32'(CS_n), 32'hF);
  endtask

  initial begin
    int  cnt;
    bit  seen;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("ready_in_reset", 32'(ready), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_cs", 32'(CS_n), 32'hF);
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_arrived", 32'(arrived), 32'd0);
    check("rst_dataO", 32'(dataO), 32'd0);

    // Mode 0, MSB first: A5 out, 3C back
    xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5, 8'h3C, 4'b1110, 1'b0);
    // Modes 1..3 with 5A out, 96 back; mode 2 also has inputs disturbed mid-transfer
    xfer(8'h5A, 2'd1, 1'b0, 1'b1, 1'b0, 8'h96, 8'h5A, 8'h96, 4'b1101, 1'b0);
    xfer(8'h5A, 2'd0, 1'b1, 1'b0, 1'b0, 8'h96, 8'h5A, 8'h96, 4'b1110, 1'b1);
    xfer(8'h5A, 2'd2, 1'b1, 1'b1, 1'b0, 8'h96, 8'h5A, 8'h96, 4'b1011, 1'b0);

    // Idle SCLK keeps the latched cpol until the next accept
    @(negedge Clock);
    cpol = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("idle_cpol_held", 32'(SCLK), 32'd1);

    // LSB first: 01 out (MOSI high only for the first bit), slave sends 1 first
    xfer(8'h01, 2'd0, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 8'h01, 4'b1110, 1'b0);

    // Highest select on NCS=4; out-of-range select on the NCS=3 instance
    xfer(8'h33, 2'd3, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h33, 8'hC3, 4'b0111, 1'b0);
    check("dummy_cs_n3", 32'(cs3_acc), 32'h7);
    check("dummy_arrived_n3", 32'(arr3_end), 32'd1);

    // Reset in the middle of bit 4
    @(negedge Clock);
    data = 8'hA5; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    s_seq = 8'h3C; s_cpha = 1'b0; send = 1'b1;
    @(posedge Clock); #1;
    send = 1'b0;
    repeat (17) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("abort_cs", 32'(CS_n), 32'hF);
    check("abort_sclk", 32'(SCLK), 32'd0);
    check("abort_mosi", 32'(MOSI), 32'd0);
    check("abort_arrived", 32'(arrived), 32'd0);
    check("abort_dataO", 32'(dataO), 32'd0);
    Reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge Clock); #1;
      if (arrived) seen = 1'b1;
    end
    check("abort_no_arrived", 32'(seen), 32'd0);
    xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5, 8'h3C, 4'b1110, 1'b0);

    // Back-to-back with send held high
    @(negedge Clock);
    data = 8'h81; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    s_seq = 8'h18; s_cpha = 1'b0; send = 1'b1;
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 100) begin
      @(posedge Clock); #1;
      cnt++;
      if (arrived) seen = 1'b1;
    end
    check("b2b_first_arrived", 32'(seen), 32'd1);
    check("b2b_gap_cs", 32'(CS_n), 32'hF);
    check("b2b_gap_ready", 32'(ready), 32'd1);
    @(posedge Clock); #1;
    send = 1'b0;
    check("b2b_restart_cs", 32'(CS_n), 32'b1110);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 100) begin
      @(posedge Clock); #1;
      cnt++;
      if (arrived) seen = 1'b1;
    end
    check("b2b_latency", 32'(cnt), 32'd34);
    check("b2b_dataO", 32'(dataO), 32'h18);
    check("b2b_mosi_seq", 32'(mosi_seq), 32'h81);

`ifdef SPI_LOOPBACK_EN
    // Loopback: own MOSI comes back, no chip select driven
    @(negedge Clock);
    loopback = 1'b1;
    xfer(8'hC3, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 4'hF, 1'b0);
    @(negedge Clock);
    data = 8'h3A; send = 1'b1;
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 100) begin
      @(posedge Clock); #1;
      cnt++;
      if (arrived) seen = 1'b1;
      check("lb_cs_high", 32'(CS_n), 32'hF);
    end
    check("lb_first_dataO", 32'(dataO), 32'h3A);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 100) begin
      @(posedge Clock); #1;
      cnt++;
      if (arrived) seen = 1'b1;
    end
    send = 1'b0;
    check("lb_b2b_spacing", 32'(cnt), 32'd35);
    check("lb_b2b_dataO", 32'(dataO), 32'h3A);
    loopback = 1'b0;
`endif

    repeat (5) @(posedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
